// File: rtl/invert_serial_pkg.sv
// Shared types for the bit-serial two's-complement negator.
package invert_serial_pkg;

    // ARMED: no '1' seen yet in this word (copy bits).
    // INVERTING: first '1' already passed (invert bits).
    typedef enum logic {
        ARMED     = 1'b0,
        INVERTING = 1'b1
    } neg_state_e;

    // Counter width for a framed word; a 1-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/invert_serial_if.sv
// Serial bit stream bundle: one input bit and one output bit per clock.
interface invert_serial_if;
    logic i;
    logic y;

    modport master (output i, input y);
    modport slave  (input i, output y);
endinterface

// File: rtl/invert_serial.sv
// Bit-serial two's-complement negator: copies bits up to and including the
// first '1' of a word, then inverts every later bit. LSB first, one bit/clock.
module invert_serial
    import invert_serial_pkg::*;
#(
    parameter int WORD_W  = 0,  // 0 = one unframed word until reset
    parameter int REG_OUT = 0   // 1 = registered output, one cycle later
) (
    input  logic i,
    input  logic rst_n,
    input  logic clk,
    output logic y
);

    neg_state_e state_q, state_d;
    logic       wrap;
    logic       y_c;

    // Mealy output: the bit that carries the first '1' still sees ARMED.
    assign y_c = i ^ (state_q == INVERTING);

    generate
        if (WORD_W > 0) begin : g_frame
            localparam int CW = cnt_width(WORD_W);
            logic [CW-1:0] cnt;

            assign wrap = (cnt == CW'(WORD_W - 1));

            // Bit position within the word, wrapping at the last bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt <= '0;
                else if (wrap) cnt <= '0;
                else cnt <= cnt + 1'b1;
            end
        end else begin : g_free
            assign wrap = 1'b0;
        end
    endgenerate

    // Next state: word boundary re-arms ahead of any '1' on the last bit.
    always_comb begin
        state_d = state_q;
        if (wrap) state_d = ARMED;
        else if (i) state_d = INVERTING;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARMED;
        else state_q <= state_d;
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic y_q;

            // Registered output, cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) y_q <= 1'b0;
                else y_q <= y_c;
            end

            assign y = y_q;
        end else begin : g_comb
            assign y = y_c;
        end
    endgenerate

endmodule

// File: tb/tb_invert_serial.sv
// Directed bench for invert_serial: default, framed (WORD_W=4) and
// registered-output (REG_OUT=1) instances driven from one shared stream.
module tb_invert_serial;

    logic clk;
    logic rst_n;
    logic y_w;
    logic y_r;
    int   n_tests;
    int   n_fail;

    invert_serial_if bus ();

    invert_serial #(.WORD_W(0), .REG_OUT(0)) dut0 (
        .i(bus.i), .rst_n(rst_n), .clk(clk), .y(bus.y)
    );
    invert_serial #(.WORD_W(4), .REG_OUT(0)) dut_w (
        .i(bus.i), .rst_n(rst_n), .clk(clk), .y(y_w)
    );
    invert_serial #(.WORD_W(0), .REG_OUT(1)) dut_r (
        .i(bus.i), .rst_n(rst_n), .clk(clk), .y(y_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive reset level and bit at the falling edge, let outputs settle.
    task automatic drive(input logic r, input logic b);
        @(negedge clk);
        rst_n = r;
        bus.i = b;
        #1;
    endtask

    // Hold reset low across one rising edge; next drive() releases it.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i   = 1'b0;

        // 1. reset hold: y follows i, registered output held at 0
        drive(1'b0, 1'b1); chk("rst_pass0", bus.y, 1'b1); chk("rst_yq0", y_r, 1'b0);
        drive(1'b0, 1'b0); chk("rst_pass1", bus.y, 1'b0);
        drive(1'b0, 1'b1); chk("rst_pass2", bus.y, 1'b1); chk("rst_yq2", y_r, 1'b0);

        // 2. negate 6: 0,1,1,0 -> 0,1,0,1 ; registered copy one cycle behind
        drive(1'b1, 1'b0); chk("neg6_b0", bus.y, 1'b0); chk("neg6_r_rst", y_r, 1'b0);
        drive(1'b1, 1'b1); chk("neg6_b1", bus.y, 1'b1); chk("neg6_r0", y_r, 1'b0);
        drive(1'b1, 1'b1); chk("neg6_b2", bus.y, 1'b0); chk("neg6_r1", y_r, 1'b1);
        drive(1'b1, 1'b0); chk("neg6_b3", bus.y, 1'b1); chk("neg6_r2", y_r, 1'b0);
        drive(1'b1, 1'b0);                              chk("neg6_r3", y_r, 1'b1);

        // 3. leading one: 1,0,1,1,0,0 -> 1,1,0,0,1,1
        do_reset();
        drive(1'b1, 1'b1); chk("lead_b0", bus.y, 1'b1);
        drive(1'b1, 1'b0); chk("lead_b1", bus.y, 1'b1);
        drive(1'b1, 1'b1); chk("lead_b2", bus.y, 1'b0);
        drive(1'b1, 1'b1); chk("lead_b3", bus.y, 1'b0);
        drive(1'b1, 1'b0); chk("lead_b4", bus.y, 1'b1);
        drive(1'b1, 1'b0); chk("lead_b5", bus.y, 1'b1);

        // 4. zero word stays zero, first '1' passes, later bits invert
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0); chk("zero_w", bus.y, 1'b0);
        end
        drive(1'b1, 1'b1); chk("zero_one", bus.y, 1'b1);
        drive(1'b1, 1'b0); chk("zero_inv0", bus.y, 1'b1);
        drive(1'b1, 1'b1); chk("zero_inv1", bus.y, 1'b0);

        // 5. mid-stream reset clears state immediately
        do_reset();
        drive(1'b1, 1'b1); chk("mid_b0", bus.y, 1'b1);
        drive(1'b1, 1'b0); chk("mid_b1", bus.y, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.i = 1'b0;
        #1; chk("mid_async", bus.y, 1'b0);
        @(posedge clk);
        drive(1'b1, 1'b0); chk("mid_n0", bus.y, 1'b0);
        drive(1'b1, 1'b1); chk("mid_n1", bus.y, 1'b1);
        drive(1'b1, 1'b1); chk("mid_n2", bus.y, 1'b0);

        // 6. WORD_W=4: 0,1,1,0 | 1,0,0,0 -> 0,1,0,1 | 1,1,1,1 ; unframed keeps inverting
        do_reset();
        drive(1'b1, 1'b0); chk("w4_b0", y_w, 1'b0); chk("w4_u0", bus.y, 1'b0);
        drive(1'b1, 1'b1); chk("w4_b1", y_w, 1'b1); chk("w4_u1", bus.y, 1'b1);
        drive(1'b1, 1'b1); chk("w4_b2", y_w, 1'b0); chk("w4_u2", bus.y, 1'b0);
        drive(1'b1, 1'b0); chk("w4_b3", y_w, 1'b1); chk("w4_u3", bus.y, 1'b1);
        drive(1'b1, 1'b1); chk("w4_b4", y_w, 1'b1); chk("w4_u4", bus.y, 1'b0);
        drive(1'b1, 1'b0); chk("w4_b5", y_w, 1'b1); chk("w4_u5", bus.y, 1'b1);
        drive(1'b1, 1'b0); chk("w4_b6", y_w, 1'b1);
        drive(1'b1, 1'b0); chk("w4_b7", y_w, 1'b1);

        // 6b. WORD_W=4 most-negative word 0,0,0,1 maps to itself, then re-arms
        drive(1'b1, 1'b0); chk("w4_mn0", y_w, 1'b0);
        drive(1'b1, 1'b0); chk("w4_mn1", y_w, 1'b0);
        drive(1'b1, 1'b0); chk("w4_mn2", y_w, 1'b0);
        drive(1'b1, 1'b1); chk("w4_mn3", y_w, 1'b1);
        drive(1'b1, 1'b0); chk("w4_rearm", y_w, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
